addn_pipe: RTL and testbench

- Parametrised, pipelined N-bit adder/subtractor; successor to the combinational ripple `addn`.
- Operand is split into STAGES equal chunks; one chunk's carry chain resolves per pipeline stage, so the critical path is N/STAGES full-adder cells.
- Adds carry-in, subtract mode, carry-out, signed overflow and valid/ready handshakes on both sides.
- Sits between operand producers (register file, datapath muxes) and result consumers.

---
 rtl/addn_pipe.sv | 119 +++++++++++
 tb/tb_addn_pipe.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/addn_pipe.sv
// Pipelined N-bit adder/subtractor: each stage resolves one W-bit chunk's carry chain.
// Global stall on the output handshake; valid bits shift with the datapath, bubbles included.
module addn_pipe #(
    parameter int unsigned N      = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    input  logic         c_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         c_out,
    output logic         overflow
);

    localparam int unsigned W = (STAGES == 0) ? 1 : N / STAGES;

    if (STAGES == 0 || STAGES > N || (N % ((STAGES == 0) ? 1 : STAGES)) != 0) begin : g_bad_params
        $error("addn_pipe: STAGES must satisfy 1 <= STAGES <= N and divide N");
    end

    logic w_adv;

    assign w_adv    = ~out_valid | out_ready;
    assign in_ready = w_adv;

    // Stage k consumes the low W bits of the operands it receives and forwards the rest.
    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int unsigned RW = N - k * W;
        localparam int unsigned SW = (k + 1) * W;

        logic [RW-1:0] w_a;
        logic [RW-1:0] w_b;
        logic          w_c;
        logic          w_v;
        logic [W:0]    w_add;
        logic          r_v;
        logic          r_c;
        logic [SW-1:0] r_s;

        assign w_add = {1'b0, w_a[W-1:0]} + {1'b0, w_b[W-1:0]} + {{W{1'b0}}, w_c};

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_v <= 1'b0;
                r_c <= 1'b0;
            end else if (w_adv) begin
                r_v <= w_v;
                r_c <= w_add[W];
            end
        end

        if (k == 0) begin : g_head
            assign w_a = a;
            assign w_b = sub ? ~b : b;
            assign w_c = c_in ^ sub;
            assign w_v = in_valid;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_s <= '0;
                end else if (w_adv) begin
                    r_s <= w_add[W-1:0];
                end
            end
        end else begin : g_body
            assign w_a = g_st[k-1].g_fwd.r_a;
            assign w_b = g_st[k-1].g_fwd.r_b;
            assign w_c = g_st[k-1].r_c;
            assign w_v = g_st[k-1].r_v;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_s <= '0;
                end else if (w_adv) begin
                    r_s <= {w_add[W-1:0], g_st[k-1].r_s};
                end
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [RW-W-1:0] r_a;
            logic [RW-W-1:0] r_b;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_adv) begin
                    r_a <= w_a[RW-1:W];
                    r_b <= w_b[RW-1:W];
                end
            end
        end else begin : g_last
            logic r_ov;

            // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ov <= 1'b0;
                end else if (w_adv) begin
                    r_ov <= w_add[W] ^ w_a[W-1] ^ w_b[W-1] ^ w_add[W-1];
                end
            end
        end
    end

    assign out_valid = g_st[STAGES-1].r_v;
    assign sum       = g_st[STAGES-1].r_s;
    assign c_out     = g_st[STAGES-1].r_c;
    assign overflow  = g_st[STAGES-1].g_last.r_ov;

endmodule

// File: tb/tb_addn_pipe.sv
// Directed bench for addn_pipe across four parameterisations sharing clock and reset.
module tb_addn_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    // N=8, STAGES=2
    logic       p8_iv, p8_ir, p8_ov, p8_or, p8_sub, p8_ci, p8_co, p8_ovf;
    logic [7:0] p8_a, p8_b, p8_s;
    // defaults: N=32, STAGES=4
    logic        p32_iv, p32_ir, p32_ov, p32_or, p32_sub, p32_ci, p32_co, p32_ovf;
    logic [31:0] p32_a, p32_b, p32_s;
    // N=16, STAGES=1 and STAGES=16
    logic        q1_iv, q1_ir, q1_ov, q1_or, q1_co, q1_ovf;
    logic        q16_iv, q16_ir, q16_ov, q16_or, q16_co, q16_ovf;
    logic        v_sub, v_ci;
    logic [15:0] v_a, v_b, q1_s, q16_s;

    addn_pipe #(.N(8), .STAGES(2)) u_p8 (
        .clk(clk), .rst_n(rst_n), .in_valid(p8_iv), .in_ready(p8_ir), .a(p8_a), .b(p8_b),
        .sub(p8_sub), .c_in(p8_ci), .out_valid(p8_ov), .out_ready(p8_or), .sum(p8_s),
        .c_out(p8_co), .overflow(p8_ovf));

    addn_pipe u_p32 (
        .clk(clk), .rst_n(rst_n), .in_valid(p32_iv), .in_ready(p32_ir), .a(p32_a), .b(p32_b),
        .sub(p32_sub), .c_in(p32_ci), .out_valid(p32_ov), .out_ready(p32_or), .sum(p32_s),
        .c_out(p32_co), .overflow(p32_ovf));

    addn_pipe #(.N(16), .STAGES(1)) u_q1 (
        .clk(clk), .rst_n(rst_n), .in_valid(q1_iv), .in_ready(q1_ir), .a(v_a), .b(v_b),
        .sub(v_sub), .c_in(v_ci), .out_valid(q1_ov), .out_ready(q1_or), .sum(q1_s),
        .c_out(q1_co), .overflow(q1_ovf));

    addn_pipe #(.N(16), .STAGES(16)) u_q16 (
        .clk(clk), .rst_n(rst_n), .in_valid(q16_iv), .in_ready(q16_ir), .a(v_a), .b(v_b),
        .sub(v_sub), .c_in(v_ci), .out_valid(q16_ov), .out_ready(q16_or), .sum(q16_s),
        .c_out(q16_co), .overflow(q16_ovf));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one beat to the 8-bit instance and check it two cycles later.
    task automatic run8(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                        input logic ts, input logic tc, input logic [7:0] es,
                        input logic ec, input logic eo);
        @(negedge clk);
        p8_a = ta; p8_b = tb_; p8_sub = ts; p8_ci = tc; p8_iv = 1'b1;
        @(negedge clk);
        p8_iv = 1'b0;
        chk({tag, "_lat"}, 64'(p8_ov), 64'd0);
        @(negedge clk);
        chk({tag, "_valid"}, 64'(p8_ov), 64'd1);
        chk({tag, "_sum"}, 64'(p8_s), 64'(es));
        chk({tag, "_cout"}, 64'(p8_co), 64'(ec));
        chk({tag, "_ovf"}, 64'(p8_ovf), 64'(eo));
    endtask

    logic [15:0] va [5];
    logic [15:0] vb [5];
    logic [15:0] vs [5];
    logic        vsub [5];
    logic        vci [5];
    logic        vco [5];
    logic        vov [5];

    initial begin
        p8_iv = 0; p8_or = 1; p8_a = '0; p8_b = '0; p8_sub = 0; p8_ci = 0;
        p32_iv = 0; p32_or = 1; p32_a = '0; p32_b = '0; p32_sub = 0; p32_ci = 0;
        q1_iv = 0; q1_or = 1; q16_iv = 0; q16_or = 1;
        v_a = '0; v_b = '0; v_sub = 0; v_ci = 0;
        va   = '{16'h1234, 16'hFFFF, 16'h8000, 16'h0000, 16'h7000};
        vb   = '{16'h4321, 16'h0001, 16'h0001, 16'h0001, 16'h1000};
        vsub = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vci  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vs   = '{16'h5555, 16'h0000, 16'h7FFF, 16'hFFFE, 16'h8001};
        vco  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vov  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

        // Reset state
        #3;
        chk("rst_valid", 64'(p32_ov), 64'd0);
        chk("rst_sum", 64'(p32_s), 64'd0);
        chk("rst_cout", 64'(p32_co), 64'd0);
        chk("rst_ovf", 64'(p32_ovf), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 64'(p32_ir), 64'd1);

        // 8-bit, two stages
        run8("add7f", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        run8("sub5m7", 8'h05, 8'h07, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0);
        run8("sub80", 8'h80, 8'h01, 1'b1, 1'b1, 8'h7E, 1'b1, 1'b1);

        // Back-to-back stream: i + 0xFFFFFFFF + 1 == i with carry out
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            chk("strm_ready", 64'(p32_ir), 64'd1);
            if (j >= 4) begin
                chk("strm_valid", 64'(p32_ov), 64'd1);
                chk("strm_sum", 64'(p32_s), 64'(j - 4));
                chk("strm_cout", 64'(p32_co), 64'd1);
                chk("strm_ovf", 64'(p32_ovf), 64'd0);
            end else begin
                chk("strm_idle", 64'(p32_ov), 64'd0);
            end
            if (j < 8) begin
                p32_a = 32'(j); p32_b = 32'hFFFF_FFFF; p32_ci = 1'b1; p32_iv = 1'b1;
            end else begin
                p32_iv = 1'b0;
            end
        end

        // Stall with a full pipe and a pending input beat
        p32_b = '0; p32_ci = 1'b0;
        for (int j = 0; j < 15; j++) begin
            @(negedge clk);
            if (j < 4) begin
                chk("stl_fill", 64'(p32_ov), 64'd0);
                p32_a = 32'h10 + 32'(j); p32_iv = 1'b1;
            end else if (j == 4) begin
                chk("stl_first", 64'(p32_s), 64'h10);
                chk("stl_rdy_pre", 64'(p32_ir), 64'd1);
                p32_or = 1'b0; p32_a = 32'h14;
            end else if (j < 10) begin
                chk("stl_in_ready", 64'(p32_ir), 64'd0);
                chk("stl_valid", 64'(p32_ov), 64'd1);
                chk("stl_hold", 64'(p32_s), 64'h10);
                if (j == 9) p32_or = 1'b1;
            end else if (j < 14) begin
                chk("stl_drain_v", 64'(p32_ov), 64'd1);
                chk("stl_drain", 64'(p32_s), 64'h11 + 64'(j - 10));
                p32_iv = 1'b0;
            end else begin
                chk("stl_empty", 64'(p32_ov), 64'd0);
            end
        end

        // Asynchronous reset with three beats in flight
        p32_b = 32'h200;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            if (j < 3) begin
                p32_a = 32'hFFFF_FF00 + 32'(j); p32_iv = 1'b1;
            end else begin
                p32_iv = 1'b0;
            end
        end
        chk("ar_pre_valid", 64'(p32_ov), 64'd1);
        chk("ar_pre_sum", 64'(p32_s), 64'h100);
        chk("ar_pre_cout", 64'(p32_co), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", 64'(p32_ov), 64'd0);
        chk("ar_sum", 64'(p32_s), 64'd0);
        chk("ar_cout", 64'(p32_co), 64'd0);
        chk("ar_in_ready", 64'(p32_ir), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            chk("ar_no_stale", 64'(p32_ov), 64'd0);
        end
        for (int j = 0; j < 6; j++) begin
            if (j >= 1 && j != 4) chk("ar_new_lat", 64'(p32_ov), 64'd0);
            if (j == 4) begin
                chk("ar_new_valid", 64'(p32_ov), 64'd1);
                chk("ar_new_sum", 64'(p32_s), 64'h3);
                chk("ar_new_cout", 64'(p32_co), 64'd0);
            end
            if (j == 0) begin
                p32_a = 32'h1; p32_b = 32'h2; p32_iv = 1'b1;
            end else begin
                p32_iv = 1'b0;
            end
            @(negedge clk);
        end

        // 16-bit, STAGES=1 (latency 1) and STAGES=16 (latency 16)
        for (int j = 0; j < 22; j++) begin
            @(negedge clk);
            if (j >= 1 && j <= 5) begin
                chk("s1_valid", 64'(q1_ov), 64'd1);
                chk("s1_sum", 64'(q1_s), 64'(vs[j-1]));
                chk("s1_cout", 64'(q1_co), 64'(vco[j-1]));
                chk("s1_ovf", 64'(q1_ovf), 64'(vov[j-1]));
            end else begin
                chk("s1_idle", 64'(q1_ov), 64'd0);
            end
            if (j >= 16 && j <= 20) begin
                chk("s16_valid", 64'(q16_ov), 64'd1);
                chk("s16_sum", 64'(q16_s), 64'(vs[j-16]));
                chk("s16_cout", 64'(q16_co), 64'(vco[j-16]));
                chk("s16_ovf", 64'(q16_ovf), 64'(vov[j-16]));
            end else begin
                chk("s16_idle", 64'(q16_ov), 64'd0);
            end
            if (j < 5) begin
                v_a = va[j]; v_b = vb[j]; v_sub = vsub[j]; v_ci = vci[j];
                q1_iv = 1'b1; q16_iv = 1'b1;
            end else begin
                q1_iv = 1'b0; q16_iv = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
